// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache refill path: Wishbone burst
// encodings and the line-fill state encoding.
package icache_pkg;

   localparam logic [2:0] CTI_INC     = 3'b010;
   localparam logic [2:0] CTI_END     = 3'b111;
   localparam logic [2:0] CTI_CLASSIC = 3'b000;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_BURST      = 2'd1,
      ST_RETRY_WAIT = 2'd2,
      ST_DONE       = 2'd3
   } fill_state_e;

   // Wrapping burst length code matching the cache line size.
   function automatic logic [1:0] bte_for(input int line_words);
      case (line_words)
         4:       bte_for = 2'b01;
         16:      bte_for = 2'b11;
         default: bte_for = 2'b10;
      endcase
   endfunction

endpackage

// File: rtl/icache_line_buf.sv
// Line assembly buffer: one word written per beat at its line index,
// whole line visible on a flat bus with word 0 in the LSBs.
module icache_line_buf
   import icache_pkg::*;
#(
   parameter int LINE_WORDS = 8,
   parameter int DATA_W     = 32,
   parameter int IDX_W      = $clog2(LINE_WORDS)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         we,
   input  logic [IDX_W-1:0]             widx,
   input  logic [DATA_W-1:0]            wdata,
   output logic [LINE_WORDS*DATA_W-1:0] rdata
);

   logic [LINE_WORDS-1:0][DATA_W-1:0] mem;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem <= '0;
      end else if (we) begin
         mem[widx] <= wdata;
      end
   end

   assign rdata = mem;

endmodule

// File: rtl/icache_line_fill.sv
// Wishbone line refill engine: critical-word-first wrapping burst with early
// critical-word forwarding, bounded retry, error reporting and flush abort.
module icache_line_fill
   import icache_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LINE_WORDS = 8,
   parameter int MAX_RETRY  = 3
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         req_valid,
   input  logic [ADDR_W-1:0]            req_addr,
   output logic                         req_ready,
   input  logic                         flush,
   output logic                         crit_valid,
   output logic [DATA_W-1:0]            crit_data,
   output logic                         line_valid,
   output logic                         line_err,
   output logic [ADDR_W-1:0]            line_addr,
   output logic [LINE_WORDS*DATA_W-1:0] line_data,
   output logic                         busy,
   input  logic                         wb_ack_i,
   input  logic                         wb_err_i,
   input  logic                         wb_rty_i,
   input  logic [DATA_W-1:0]            wb_dat_i,
   output logic                         wb_cyc_o,
   output logic                         wb_stb_o,
   output logic                         wb_we_o,
   output logic [ADDR_W-1:0]            wb_adr_o,
   output logic [3:0]                   wb_sel_o,
   output logic [DATA_W-1:0]            wb_dat_o,
   output logic [2:0]                   wb_cti_o,
   output logic [1:0]                   wb_bte_o
);

   localparam int IDX_W = $clog2(LINE_WORDS);
   localparam int OFF_W = IDX_W + 2;
   localparam int RTY_W = $clog2(MAX_RETRY + 2);
   localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

   fill_state_e       state;
   logic [ADDR_W-1:0] base;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  beat;
   logic [RTY_W-1:0]  rty_cnt;
   logic              err_q;
   logic              crit_q;
   logic              buf_we;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^req_addr[1:0];

   // Request handshake: a request is taken on a cycle where req_valid and
   // req_ready are both high and flush is low; req_ready is high only in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         base      <= '0;
         idx       <= '0;
         beat      <= '0;
         rty_cnt   <= '0;
         err_q     <= 1'b0;
         crit_q    <= 1'b0;
         crit_data <= '0;
      end else begin
         crit_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid && !flush) begin
                  base    <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                  idx     <= req_addr[OFF_W-1:2];
                  beat    <= '0;
                  rty_cnt <= '0;
                  err_q   <= 1'b0;
                  state   <= ST_BURST;
               end
            end
            ST_BURST: begin
               // Only the highest-priority termination in a cycle takes effect.
               if (flush) begin
                  state <= ST_IDLE;
               end else if (wb_err_i) begin
                  err_q <= 1'b1;
                  state <= ST_DONE;
               end else if (wb_rty_i) begin
                  if (rty_cnt == RTY_W'(MAX_RETRY)) begin
                     err_q <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     rty_cnt <= rty_cnt + 1'b1;
                     state   <= ST_RETRY_WAIT;
                  end
               end else if (wb_ack_i) begin
                  idx     <= idx + 1'b1;
                  beat    <= beat + 1'b1;
                  rty_cnt <= '0;
                  if (beat == '0) begin
                     crit_q    <= 1'b1;
                     crit_data <= wb_dat_i;
                  end
                  if (beat == LAST_BEAT) begin
                     state <= ST_DONE;
                  end
               end
            end
            ST_RETRY_WAIT: state <= flush ? ST_IDLE : ST_BURST;
            ST_DONE:       state <= ST_IDLE;
            default:       state <= ST_IDLE;
         endcase
      end
   end

   assign buf_we = (state == ST_BURST) && wb_ack_i && !wb_rty_i && !wb_err_i && !flush;

   icache_line_buf #(
      .LINE_WORDS (LINE_WORDS),
      .DATA_W     (DATA_W),
      .IDX_W      (IDX_W)
   ) u_line_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (buf_we),
      .widx  (idx),
      .wdata (wb_dat_i),
      .rdata (line_data)
   );

   assign req_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign wb_cyc_o  = (state == ST_BURST);
   assign wb_stb_o  = (state == ST_BURST);
   assign wb_we_o   = 1'b0;
   assign wb_sel_o  = 4'hf;
   assign wb_dat_o  = '0;
   assign wb_adr_o  = base | {{(ADDR_W-OFF_W){1'b0}}, idx, 2'b00};
   assign wb_cti_o  = (state != ST_BURST) ? CTI_CLASSIC :
                      (beat == LAST_BEAT) ? CTI_END : CTI_INC;
   assign wb_bte_o  = bte_for(LINE_WORDS);

   // A flush in the pulse cycle cancels the pulse as well as the refill.
   assign crit_valid = crit_q && !flush;
   assign line_valid = (state == ST_DONE) && !flush;
   assign line_err   = line_valid && err_q;
   assign line_addr  = base;

endmodule

// File: tb/tb_icache_line_fill.sv
// Bench for icache_line_fill: Wishbone slave model with retry/error/stall
// injection, expected beat addresses kept in a queue and checked per ack.
module tb_icache_line_fill;

  localparam int LW        = 8;
  localparam int LW4       = 4;
  localparam int MAX_RETRY = 3;
  localparam int LINE_BITS = LW * 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- DUT (LINE_WORDS = 8) ----------------
  logic                 req_valid, req_ready, flush;
  logic [31:0]          req_addr;
  logic                 crit_valid, line_valid, line_err, busy;
  logic [31:0]          crit_data, line_addr;
  logic [LINE_BITS-1:0] line_data;
  logic                 ack, err, rty;
  logic [31:0]          dat;
  logic                 wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0]          wb_adr_o, wb_dat_o;
  logic [3:0]           wb_sel_o;
  logic [2:0]           wb_cti_o;
  logic [1:0]           wb_bte_o;

  icache_line_fill #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(LW), .MAX_RETRY(MAX_RETRY)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .flush(flush), .crit_valid(crit_valid), .crit_data(crit_data), .line_valid(line_valid),
    .line_err(line_err), .line_addr(line_addr), .line_data(line_data), .busy(busy),
    .wb_ack_i(ack), .wb_err_i(err), .wb_rty_i(rty), .wb_dat_i(dat),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o)
  );

  // ---------------- DUT (LINE_WORDS = 4) ----------------
  logic                 req_valid4, req_ready4, flush4;
  logic [31:0]          req_addr4;
  logic                 crit_valid4, line_valid4, line_err4, busy4;
  logic [31:0]          crit_data4, line_addr4;
  logic [LW4*32-1:0]    line_data4;
  logic                 ack4, err4, rty4;
  logic [31:0]          dat4;
  logic                 wb_cyc_o4, wb_stb_o4, wb_we_o4;
  logic [31:0]          wb_adr_o4, wb_dat_o4;
  logic [3:0]           wb_sel_o4;
  logic [2:0]           wb_cti_o4;
  logic [1:0]           wb_bte_o4;

  icache_line_fill #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(LW4), .MAX_RETRY(MAX_RETRY)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid4), .req_addr(req_addr4), .req_ready(req_ready4),
    .flush(flush4), .crit_valid(crit_valid4), .crit_data(crit_data4), .line_valid(line_valid4),
    .line_err(line_err4), .line_addr(line_addr4), .line_data(line_data4), .busy(busy4),
    .wb_ack_i(ack4), .wb_err_i(err4), .wb_rty_i(rty4), .wb_dat_i(dat4),
    .wb_cyc_o(wb_cyc_o4), .wb_stb_o(wb_stb_o4), .wb_we_o(wb_we_o4), .wb_adr_o(wb_adr_o4),
    .wb_sel_o(wb_sel_o4), .wb_dat_o(wb_dat_o4), .wb_cti_o(wb_cti_o4), .wb_bte_o(wb_bte_o4)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp4_q[$];

  task automatic check(input string tag, input logic [LINE_BITS-1:0] got, input logic [LINE_BITS-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Slave memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- driver: one refill on the 8-word DUT ----------------
  // *_beat arguments are 1-based beat numbers (0 = not used).
  task automatic run_fill(input logic [31:0] addr, input int rty_beat, input int n_rty,
                          input int err_beat, input int flush_beat, input int rst_beat,
                          input bit stall_en);
    logic [31:0]          base, a;
    logic [LINE_BITS-1:0] exp_line;
    int cidx, c, acked, rty_left, n_stall, first_ack_c, end_c;
    bit expect_err, seen_crit, seen_lv, prev_rty, done;
    base = addr & ~32'(LW * 4 - 1);
    cidx = int'((addr >> 2) % LW);
    exp_q.delete();
    for (int i = 0; i < LW; i++) exp_q.push_back(base + 32'(((cidx + i) % LW) * 4));
    for (int i = 0; i < LW; i++) exp_line[i*32 +: 32] = data_of(base + 32'(i * 4));
    expect_err = (err_beat > 0) || (rty_beat > 0 && n_rty > MAX_RETRY);
    acked = 0; rty_left = n_rty; n_stall = 0; first_ack_c = 0; end_c = 0;
    seen_crit = 0; seen_lv = 0; prev_rty = 0; done = 0;

    @(negedge clk);
    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_addr  = addr;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    check("cyc_rise", wb_cyc_o, 1'b1);
    c = 1;
    while (!done && c < 300) begin
      ack = 0; rty = 0; err = 0; flush = 0; dat = '0;
      if (prev_rty) check("rty_gap_cyc", wb_cyc_o, 1'b0);
      prev_rty = 0;
      if (crit_valid) begin
        seen_crit = 1;
        check("crit_cycle", c, first_ack_c + 1);
        check("crit_data", crit_data, data_of(addr & ~32'h3));
      end
      if (line_valid) begin
        seen_lv = 1;
        done    = 1;
        check("line_err", line_err, expect_err);
        check("line_addr", line_addr, base);
        check("busy_done", busy, 1'b1);
        if (expect_err) begin
          check("lv_cycle_err", c, end_c + 1);
        end else begin
          check("lv_cycle", c, LW + 1 + 2 * (n_rty - rty_left) + n_stall);
          check("line_data", line_data, exp_line);
          check("q_empty", exp_q.size(), 0);
        end
      end else if (rst_beat > 0 && acked == rst_beat - 1 && wb_cyc_o) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_cyc", {wb_cyc_o, wb_stb_o}, 2'b00);
        check("rst_ready_busy", {req_ready, busy}, 2'b10);
        check("rst_pulses", {crit_valid, line_valid}, 2'b00);
        check("rst_cti", wb_cti_o, 3'b000);
        check("rst_line_data", line_data, '0);
        check("rst_crit_data", crit_data, '0);
        check("rst_line_addr", line_addr, '0);
        @(negedge clk);
        check("rst_no_lv", line_valid, 1'b0);
        rst_n = 1'b1;
        done  = 1;
      end else if (wb_cyc_o) begin
        check("stb", wb_stb_o, 1'b1);
        check("bte8", wb_bte_o, 2'b10);
        if (exp_q.size() == 0) begin
          check("beat_overrun", 1'b1, 1'b0);
          done = 1;
        end else if (err_beat > 0 && acked == err_beat - 1) begin
          check("adr_err", wb_adr_o, exp_q[0]);
          err = 1; rty = 1; ack = 1; dat = 32'hDEAD_BEEF;
          end_c = c;
        end else if (rty_beat > 0 && acked == rty_beat - 1 && rty_left > 0) begin
          check("adr_rty", wb_adr_o, exp_q[0]);
          rty = 1; ack = 1; dat = 32'hBAD0_0BAD;
          rty_left--;
          end_c    = c;
          prev_rty = (n_rty - rty_left) <= MAX_RETRY;
        end else if (stall_en && $urandom_range(0, 2) == 0) begin
          n_stall++;
        end else begin
          check("cti", wb_cti_o, (exp_q.size() == 1) ? 3'b111 : 3'b010);
          a = exp_q.pop_front();
          check("adr", wb_adr_o, a);
          ack = 1;
          dat = data_of(a);
          acked++;
          end_c = c;
          if (acked == 1) first_ack_c = c;
          if (flush_beat == acked) begin
            flush = 1;
            @(negedge clk);
            ack = 0; flush = 0; dat = '0;
            check("flush_cyc", wb_cyc_o, 1'b0);
            check("flush_ready", req_ready, 1'b1);
            check("flush_lv", line_valid, 1'b0);
            repeat (3) begin
              @(negedge clk);
              check("flush_no_lv", line_valid, 1'b0);
            end
            done = 1;
          end
        end
      end
      if (!done) begin
        @(negedge clk);
        c++;
      end
    end
    ack = 0; rty = 0; err = 0; flush = 0; dat = '0;
    if (!done) check("timeout", 1'b0, 1'b1);
    if (seen_lv) begin
      check("crit_seen", seen_crit, acked > 0);
      @(negedge clk);
      check("ready_after", req_ready, 1'b1);
      check("lv_one_cycle", line_valid, 1'b0);
      if (!expect_err) check("line_hold", line_data, exp_line);
    end
  endtask

  // ---------------- driver: zero-wait refill on the 4-word DUT ----------------
  task automatic run_fill4(input logic [31:0] addr);
    logic [31:0]       base, a;
    logic [LW4*32-1:0] exp_line;
    int cidx, c;
    bit done;
    base = addr & ~32'(LW4 * 4 - 1);
    cidx = int'((addr >> 2) % LW4);
    exp4_q.delete();
    for (int i = 0; i < LW4; i++) exp4_q.push_back(base + 32'(((cidx + i) % LW4) * 4));
    for (int i = 0; i < LW4; i++) exp_line[i*32 +: 32] = data_of(base + 32'(i * 4));
    done = 0;
    @(negedge clk);
    check("req_ready4", req_ready4, 1'b1);
    req_valid4 = 1'b1;
    req_addr4  = addr;
    @(negedge clk);
    req_valid4 = 1'b0;
    c = 1;
    while (!done && c < 50) begin
      ack4 = 0; dat4 = '0;
      if (line_valid4) begin
        check("lv4_cycle", c, LW4 + 1);
        check("line_err4", line_err4, 1'b0);
        check("line_addr4", line_addr4, base);
        check("line_data4", line_data4, exp_line);
        done = 1;
      end else if (wb_cyc_o4) begin
        check("bte4", wb_bte_o4, 2'b01);
        if (exp4_q.size() == 0) begin
          check("beat_overrun4", 1'b1, 1'b0);
          done = 1;
        end else begin
          check("cti4", wb_cti_o4, (exp4_q.size() == 1) ? 3'b111 : 3'b010);
          a = exp4_q.pop_front();
          check("adr4", wb_adr_o4, a);
          ack4 = 1;
          dat4 = data_of(a);
        end
      end
      if (!done) begin
        @(negedge clk);
        c++;
      end
    end
    ack4 = 0;
    if (!done) check("timeout4", 1'b0, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    req_valid = 0; req_addr = '0; flush = 0; ack = 0; err = 0; rty = 0; dat = '0;
    req_valid4 = 0; req_addr4 = '0; flush4 = 0; ack4 = 0; err4 = 0; rty4 = 0; dat4 = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", req_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_cyc", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b000);
    check("reset_cti", wb_cti_o, 3'b000);
    check("reset_bte", wb_bte_o, 2'b10);
    check("reset_sel", wb_sel_o, 4'hf);
    check("reset_pulses", {crit_valid, line_valid}, 2'b00);
    check("reset_line_data", line_data, '0);
    check("reset_crit_data", crit_data, '0);
    check("reset_line_addr", line_addr, '0);
    rst_n = 1'b1;

    run_fill(32'h0000_1234, 0, 0, 0, 0, 0, 0);  // zero-wait, wrap from index 5
    run_fill(32'h0000_1234, 3, 1, 0, 0, 0, 0);  // one retry on beat 3
    run_fill(32'h0000_2000, 1, 4, 0, 0, 0, 0);  // retries exhausted before any beat
    run_fill(32'h0000_3010, 2, 3, 0, 0, 0, 0);  // exactly MAX_RETRY retries still succeed
    run_fill(32'h0000_4008, 0, 0, 4, 0, 0, 0);  // bus error on beat 4
    run_fill(32'h0000_5018, 0, 0, 0, 5, 0, 0);  // flush with ack on beat 5
    run_fill(32'h0000_6004, 0, 0, 0, 0, 2, 0);  // reset during beat 2
    run_fill(32'h0000_703C, 0, 0, 0, 0, 0, 0);  // normal refill after reset

    // flush in IDLE blocks acceptance
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; req_addr = 32'h0000_0500;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    check("flush_idle_busy", busy, 1'b0);
    check("flush_idle_cyc", wb_cyc_o, 1'b0);

    for (int k = 0; k < 4; k++)
      run_fill($urandom, $urandom_range(0, LW), $urandom_range(1, 2), 0, 0, 0, 1);

    run_fill4(32'h0000_0040);
    run_fill4(32'h0000_108C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_line_fill.md
# icache_line_fill

Parametrised Wishbone refill engine for the instruction cache: on a miss it fetches one full cache line with a critical-word-first wrapping burst, forwards the missed word early, and delivers the assembled line to the cache data array. It sits between the icache miss FSM and the Wishbone master port. It generalises the fixed 8-word incrementing refill path with configurable line size, early critical-word forwarding, retry handling, error reporting and flush abort.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, Wishbone data width; fixed at 32 in this generation
- LINE_WORDS, 8, words per cache line; legal values 4, 8, 16
- MAX_RETRY, 3, consecutive wb_rty_i terminations tolerated before reporting an error
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  miss refill request
- req_addr  in  ADDR_W  byte address of the missed instruction
- req_ready  out  1  high only in IDLE
- flush  in  1  abort the current refill; no line is delivered
- crit_valid  out  1  one-cycle pulse when the critical word is available
- crit_data  out  DATA_W  critical word
- line_valid  out  1  one-cycle pulse when the refill completes or fails
- line_err  out  1  qualifies line_valid; when high, the line data is invalid
- line_addr  out  ADDR_W  line-aligned address of the refilled line
- line_data  out  LINE_WORDS*DATA_W  assembled line, with word 0 in the LSBs
- busy  out  1  high in every state except IDLE
- wb_ack_i, wb_err_i, wb_rty_i  in  1  Wishbone transfer terminations
- wb_dat_i  in  32  Wishbone read data
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone cycle, strobe and write enable; wb_we_o is tied to 0
- wb_adr_o  out  ADDR_W  word address of the current beat
- wb_sel_o  out  4  tied to 4'hf
- wb_dat_o  out  32  tied to 0
- wb_cti_o  out  3  cycle type identifier
- wb_bte_o  out  2  burst type extension

## Operation
- States: IDLE, BURST, RETRY_WAIT, DONE.
- **IDLE**
  - req_ready is high.
  - When req_valid is high and flush is low, the block latches the line base (req_addr with the low log2(LINE_WORDS)+2 bits cleared) and the critical index (req_addr[log2(LINE_WORDS)+1:2]).
  - It clears the beat count and the retry count, then moves to BURST.
- **BURST**
  - wb_cyc_o and wb_stb_o are high. wb_adr_o = line base | (idx<<2).
  - wb_bte_o is 01 for LINE_WORDS=4, 10 for 8, 11 for 16.
  - wb_cti_o is 010, or 111 when the beat count equals LINE_WORDS-1.
- **On wb_ack_i in BURST**
  - Store wb_dat_i into line word idx.
  - Set idx to (idx+1) mod LINE_WORDS, so the address wraps within the line.
  - Increment the beat count.
  - On the first beat, register crit_data and pulse crit_valid.
  - On the last beat, move to DONE.
- **On wb_rty_i in BURST**
  - Increment the retry count. If it exceeds MAX_RETRY, report an error: move to DONE with the error flag set.
  - Otherwise move to RETRY_WAIT, which drops cyc and stb for exactly one cycle.
  - Then return to BURST, resuming at the current idx. Beats already received are kept.
- **On wb_err_i in BURST**: set the error flag and move to DONE.
- **Any wb_ack_i in BURST resets the retry count**, so only consecutive retries count toward MAX_RETRY.
- **DONE**: pulse line_valid for one cycle, with line_err equal to the error flag, then return to IDLE.
- **flush**
  - In BURST, RETRY_WAIT or DONE: on the next cycle go to IDLE with cyc and stb low, and suppress crit_valid and line_valid.
  - If an ack coincides with flush, the data is dropped.
  - In IDLE, flush blocks acceptance of a request.
- **Priority**: flush > wb_err_i > wb_rty_i > wb_ack_i. When several terminations arrive together, only the highest-priority one takes effect.
- **Reset values**: state IDLE; all strobes and pulses 0; req_ready 1; busy 0; line_data, line_addr and crit_data 0; wb_cti_o 000; wb_bte_o fixed per the parameter.

## Timing
- Request accepted at cycle T (req_valid and req_ready both high). wb_cyc_o rises at T+1.
- With a zero-wait slave (ack in every cycle from T+1):
  - crit_valid at T+2
  - last ack at T+LINE_WORDS
  - line_valid at T+LINE_WORDS+1
  - req_ready at T+LINE_WORDS+2
- A slave wait state stretches the burst one cycle per stall cycle. wb_adr_o and wb_cti_o hold steady until ack.
- Each retry adds 2 cycles: the cycle carrying rty and the RETRY_WAIT cycle.
- line_data is stable from the line_valid cycle until the next accepted request.
- Asynchronous reset mid-burst drops wb_cyc_o immediately. No line_valid is produced.

## Structure
- Shared package icache_pkg holds:
  - the cti constants CTI_INC=3'b010 and CTI_END=3'b111
  - the bte lookup function from LINE_WORDS
  - the fill state encoding
- One sub-module, icache_line_buf: a LINE_WORDS x 32 write-by-index register file with a flat read-out. The FSM, counters and Wishbone drive logic stay in the top module.

## Test plan
- LINE_WORDS=8, req_addr=0x0000_1234, zero-wait slave:
  - addresses issued are 0x1234, 0x1238, 0x123C, 0x1220 … 0x1230
  - cti=111 only on the 0x1230 beat; bte=10
  - crit_valid at T+2 with the word from 0x1234
  - line_valid at T+9 with line_addr 0x1220
- LINE_WORDS=4, req_addr=0x40 (index 0):
  - linear burst 0x40 to 0x4C; bte=01
  - line_valid at T+5 with line_err=0
- rty on beat 3, then ack:
  - cyc is low for one cycle, and the burst resumes at the beat-3 address
  - the line completes 2 cycles late with correct data
- Four consecutive rty with MAX_RETRY=3: line_valid with line_err=1. No crit_valid if no beat has landed.
- flush asserted on beat 5 together with ack: cyc drops next cycle, no line_valid, and req_ready returns the cycle after.
- rst_n pulled low during beat 2: all outputs take their reset values immediately. After release, a new request completes normally.
